// File: rtl/led_blinker_pkg.sv
// Shared types and widths for the multi-channel LED blinker.
// Mode encoding is shared by the top and every channel instance.
package led_blinker_pkg;

    localparam int MODE_W = 2;
    localparam int RATE_W = 2;

    // Number of top counter bits a channel needs to pick its blink tap.
    localparam int BLINK_TAPS = 1 << RATE_W;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_PWM   = 2'b11
    } led_mode_e;

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: boundary-loaded shadows, blink/PWM decode and the led flop.
// With LED_BLINKER_BREATHE_EN defined, PWM duty comes from a triangle ramp.
module led_pwm_channel
    import led_blinker_pkg::*;
#(
    parameter int PWM_W = 8
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic [BLINK_TAPS-1:0] cnt_top_i,
    input  logic [PWM_W-1:0]      cnt_low_i,
    input  logic                  boundary_i,
`ifdef LED_BLINKER_BREATHE_EN
    input  logic                  wrap_i,
`endif
    input  logic [MODE_W-1:0]     mode_i,
    input  logic [RATE_W-1:0]     rate_i,
    input  logic [PWM_W-1:0]      duty_i,
    output logic                  led_o
);

    led_mode_e         mode_q, mode_d;
    logic [RATE_W-1:0] rate_q, rate_d;
    logic [PWM_W-1:0]  duty_q, duty_d;
    logic [PWM_W-1:0]  duty_eff;
    logic              blink_bit;
    logic              led_q, led_d;

    always_comb begin
        mode_d = mode_q;
        rate_d = rate_q;
        duty_d = duty_q;
        if (boundary_i) begin
            mode_d = led_mode_e'(mode_i);
            rate_d = rate_i;
            duty_d = duty_i;
        end
    end

    // cnt_top_i[BLINK_TAPS-1] is the counter MSB; each rate step halves the period.
    always_comb begin
        blink_bit = cnt_top_i[BLINK_TAPS-1];
        case (rate_q)
            2'd1:    blink_bit = cnt_top_i[BLINK_TAPS-2];
            2'd2:    blink_bit = cnt_top_i[BLINK_TAPS-3];
            2'd3:    blink_bit = cnt_top_i[BLINK_TAPS-4];
            default: blink_bit = cnt_top_i[BLINK_TAPS-1];
        endcase
    end

`ifdef LED_BLINKER_BREATHE_EN
    logic [PWM_W-1:0] ramp_q, ramp_d;
    logic             ramp_down_q, ramp_down_d;

    // Endpoints are held for one step while the direction flips.
    always_comb begin
        ramp_d      = ramp_q;
        ramp_down_d = ramp_down_q;
        if (wrap_i) begin
            if (!ramp_down_q) begin
                if (&ramp_q) begin
                    ramp_down_d = 1'b1;
                end else begin
                    ramp_d = ramp_q + 1'b1;
                end
            end else begin
                if (ramp_q == '0) begin
                    ramp_down_d = 1'b0;
                end else begin
                    ramp_d = ramp_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            ramp_q      <= '0;
            ramp_down_q <= 1'b0;
        end else begin
            ramp_q      <= ramp_d;
            ramp_down_q <= ramp_down_d;
        end
    end

    assign duty_eff = ramp_q;
`else
    assign duty_eff = duty_q;
`endif

    always_comb begin
        led_d = 1'b0;
        case (mode_q)
            MODE_OFF:   led_d = 1'b0;
            MODE_ON:    led_d = 1'b1;
            MODE_BLINK: led_d = blink_bit;
            MODE_PWM:   led_d = (cnt_low_i < duty_eff);
            default:    led_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            mode_q <= MODE_OFF;
            rate_q <= '0;
            duty_q <= '0;
            led_q  <= 1'b0;
        end else begin
            mode_q <= mode_d;
            rate_q <= rate_d;
            duty_q <= duty_d;
            led_q  <= led_d;
        end
    end

    assign led_o = led_q;

endmodule

// File: rtl/led_blinker_multi.sv
// Multi-channel LED blinker: shared free-running counter plus NUM_CH channels.
// Optional breathing PWM ramp is enabled with LED_BLINKER_BREATHE_EN.
module led_blinker_multi
    import led_blinker_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 16,
    parameter int PWM_W  = 8
) (
    input  logic                      WB_CLK,
    input  logic                      WB_RST,
    input  logic [MODE_W*NUM_CH-1:0]  mode,
    input  logic [RATE_W*NUM_CH-1:0]  rate,
    input  logic [PWM_W*NUM_CH-1:0]   duty,
    output logic [NUM_CH-1:0]         led,
    output logic                      period_tick
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             boundary;

    // A boundary is the last cycle of each 2^PWM_W-cycle PWM period.
    assign boundary = &cnt_q[PWM_W-1:0];

    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        tick_d = boundary;
    end

    always_ff @(posedge WB_CLK) begin
        if (WB_RST) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

`ifdef LED_BLINKER_BREATHE_EN
    logic wrap;
    assign wrap = &cnt_q;
`endif

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            led_pwm_channel #(
                .PWM_W (PWM_W)
            ) u_ch (
                .clk        (WB_CLK),
                .srst       (WB_RST),
                .cnt_top_i  (cnt_q[CNT_W-1 -: BLINK_TAPS]),
                .cnt_low_i  (cnt_q[PWM_W-1:0]),
                .boundary_i (boundary),
`ifdef LED_BLINKER_BREATHE_EN
                .wrap_i     (wrap),
`endif
                .mode_i     (mode[gi*MODE_W +: MODE_W]),
                .rate_i     (rate[gi*RATE_W +: RATE_W]),
                .duty_i     (duty[gi*PWM_W +: PWM_W]),
                .led_o      (led[gi])
            );
        end
    endgenerate

    assign period_tick = tick_q;

endmodule

// File: tb/tb_led_blinker_multi.sv
// Self-checking bench for led_blinker_multi (CNT_W=10, PWM_W=4, NUM_CH=3).
module tb_led_blinker_multi;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 10;
    localparam int PWM_W  = 4;
    localparam int CNT_MOD = 1 << CNT_W;
    localparam int PWM_MOD = 1 << PWM_W;
`ifdef LED_BLINKER_BREATHE_EN
    localparam bit BREATHE = 1'b1;
`else
    localparam bit BREATHE = 1'b0;
`endif

    logic                     clk;
    logic                     rst;
    logic [2*NUM_CH-1:0]      mode;
    logic [2*NUM_CH-1:0]      rate;
    logic [PWM_W*NUM_CH-1:0]  duty;
    logic [NUM_CH-1:0]        led;
    logic                     period_tick;

    int n_tests = 0;
    int n_fail  = 0;

    led_blinker_multi #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .PWM_W  (PWM_W)
    ) dut (
        .WB_CLK      (clk),
        .WB_RST      (rst),
        .mode        (mode),
        .rate        (rate),
        .duty        (duty),
        .led         (led),
        .period_tick (period_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
    endtask

    // Triangle ramp value after w full counter wraps: 0..15, hold 15, 14..0, hold 0.
    function automatic int ramp_at(input int w);
        int p;
        p = w % (2 * PWM_MOD);
        if (p < PWM_MOD) return p;
        if (p == PWM_MOD) return PWM_MOD - 1;
        return 2 * PWM_MOD - 1 - p;
    endfunction

    // Expected LED for one channel given the loaded config and cycles since reset.
    function automatic logic ch_led(input logic [1:0] md, input logic [1:0] rt,
                                    input logic [PWM_W-1:0] dt, input int n);
        int c;
        int d;
        c = n % CNT_MOD;
        case (md)
            2'b00: return 1'b0;
            2'b01: return 1'b1;
            2'b10: return ((c >> (CNT_W - 1 - int'(rt))) % 2) == 1;
            default: begin
                d = BREATHE ? ramp_at(n / CNT_MOD) : int'(dt);
                return (c % PWM_MOD) < d;
            end
        endcase
    endfunction

    typedef struct {
        logic [2*NUM_CH-1:0]     mode;
        logic [2*NUM_CH-1:0]     rate;
        logic [PWM_W*NUM_CH-1:0] duty;
        int                      edges;
        logic [NUM_CH-1:0]       exp_led;
        logic                    exp_tick;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [5:0] m, input logic [5:0] r, input logic [11:0] d,
                                input int e, input logic [2:0] l, input logic t);
        vec_t v;
        v.mode = m; v.rate = r; v.duty = d; v.edges = e; v.exp_led = l; v.exp_tick = t;
        return v;
    endfunction

    logic [1:0]       sm [NUM_CH];
    logic [1:0]       sr [NUM_CH];
    logic [PWM_W-1:0] sd [NUM_CH];

    initial begin
        logic [2:0] pw;
        logic [2:0] exp_led;
        logic       exp_tick;
        int         m_n;
        int         d;

        rst  = 1'b1;
        mode = '0;
        rate = '0;
        duty = '0;
        pw   = BREATHE ? 3'b000 : 3'b010;

        // Edge k after reset release: cnt=k, led from cnt=k-1, shadows valid from edge 17.
        tbl.push_back(mk(6'h15, 6'h00, 12'h000,   15, 3'b000, 1'b0));
        tbl.push_back(mk(6'h15, 6'h00, 12'h000,   16, 3'b000, 1'b1));
        tbl.push_back(mk(6'h15, 6'h00, 12'h000,   17, 3'b111, 1'b0));
        tbl.push_back(mk(6'h15, 6'h00, 12'h000,   32, 3'b111, 1'b1));
        tbl.push_back(mk(6'h0C, 6'h00, 12'h35A,   17, pw,     1'b0));
        tbl.push_back(mk(6'h0C, 6'h00, 12'h35A,   21, pw,     1'b0));
        tbl.push_back(mk(6'h0C, 6'h00, 12'h35A,   22, 3'b000, 1'b0));
        tbl.push_back(mk(6'h0C, 6'h00, 12'h0F0,   32, 3'b000, 1'b1));
        tbl.push_back(mk(6'h0C, 6'h00, 12'h0F0,   33, pw,     1'b0));
        tbl.push_back(mk(6'h0C, 6'h00, 12'hF0F,   20, 3'b000, 1'b0));
        tbl.push_back(mk(6'h02, 6'h00, 12'h000,  512, 3'b000, 1'b1));
        tbl.push_back(mk(6'h02, 6'h00, 12'h000,  513, 3'b001, 1'b0));
        tbl.push_back(mk(6'h02, 6'h00, 12'h000, 1025, 3'b000, 1'b0));
        tbl.push_back(mk(6'h02, 6'h02, 12'h000,  128, 3'b000, 1'b1));
        tbl.push_back(mk(6'h02, 6'h02, 12'h000,  129, 3'b001, 1'b0));
        tbl.push_back(mk(6'h02, 6'h02, 12'h000,  257, 3'b000, 1'b0));
        tbl.push_back(mk(6'h21, 6'h30, 12'h000,   65, 3'b101, 1'b0));
        tbl.push_back(mk(6'h21, 6'h30, 12'h000,   40, 3'b001, 1'b0));

        // Reset state while held, with ON requested at the inputs.
        mode = 6'h15;
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_led", 32'(led), 32'h0);
            check("reset_tick", 32'(period_tick), 32'h0);
            $display("[TB] reset edge %0d led=%b tick=%b", i, led, period_tick);
        end
        rst = 1'b0;

        foreach (tbl[i]) begin
            mode = tbl[i].mode;
            rate = tbl[i].rate;
            duty = tbl[i].duty;
            do_reset(2);
            repeat (tbl[i].edges) step();
            check($sformatf("vec%0d_led", i), 32'(led), 32'(tbl[i].exp_led));
            check($sformatf("vec%0d_tick", i), 32'(period_tick), 32'(tbl[i].exp_tick));
            $display("[TB] vec %0d edges=%0d led=%b tick=%b", i, tbl[i].edges, led, period_tick);
        end

        // Mid-operation reset at cnt=600: outputs clear, shadows back to OFF, counter restarts.
        mode = 6'h15;
        rate = '0;
        duty = '0;
        do_reset(1);
        repeat (600) step();
        check("pre_rst_led", 32'(led), 32'h7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_led", 32'(led), 32'h0);
        check("mid_rst_tick", 32'(period_tick), 32'h0);
        $display("[TB] mid reset led=%b tick=%b", led, period_tick);
        for (int k = 1; k <= 17; k++) begin
            step();
            check($sformatf("post_rst%0d_led", k), 32'(led), (k <= 16) ? 32'h0 : 32'h7);
            check($sformatf("post_rst%0d_tick", k), 32'(period_tick), (k == 16) ? 32'h1 : 32'h0);
        end
        $display("[TB] post reset recovery led=%b", led);

        // Duty 5 -> 12 changed at cnt=20; new value only from the period starting at cnt=32.
        mode = 6'h0C;
        duty = 12'h050;
        do_reset(1);
        repeat (20) step();
        duty = 12'h0C0;
        for (int k = 21; k <= 48; k++) begin
            step();
            d = BREATHE ? 0 : ((k - 1 < 32) ? 5 : 12);
            exp_led = (((k - 1) % PWM_MOD) < d) ? 3'b010 : 3'b000;
            check($sformatf("duty_chg%0d", k), 32'(led), 32'(exp_led));
        end
        $display("[TB] duty change sequence done led=%b", led);

        // Randomized run against the reference model, with occasional resets.
        do_reset(1);
        m_n = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            sm[c] = '0; sr[c] = '0; sd[c] = '0;
        end
        for (int cyc = 0; cyc < 6000; cyc++) begin
            if ($urandom_range(0, 19) == 0) begin
                mode = 6'($urandom);
                rate = 6'($urandom);
                duty = 12'($urandom);
                $display("[TB] rnd cycle %0d mode=%h rate=%h duty=%h", cyc, mode, rate, duty);
            end
            rst = ($urandom_range(0, 1499) == 0);
            if (rst) begin
                exp_led  = '0;
                exp_tick = 1'b0;
                m_n      = 0;
                for (int c = 0; c < NUM_CH; c++) begin
                    sm[c] = '0; sr[c] = '0; sd[c] = '0;
                end
                $display("[TB] rnd cycle %0d reset", cyc);
            end else begin
                for (int c = 0; c < NUM_CH; c++)
                    exp_led[c] = ch_led(sm[c], sr[c], sd[c], m_n);
                exp_tick = ((m_n % PWM_MOD) == PWM_MOD - 1);
                if (exp_tick) begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        sm[c] = mode[2*c +: 2];
                        sr[c] = rate[2*c +: 2];
                        sd[c] = duty[PWM_W*c +: PWM_W];
                    end
                end
                m_n++;
            end
            step();
            check("rnd_led", 32'(led), 32'(exp_led));
            check("rnd_tick", 32'(period_tick), 32'(exp_tick));
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
